// File: rtl/bias_bank_loader_if.sv
// Loader and read-port bundle for bias_bank_loader.
// master drives load/read requests; slave is the bias storage.
interface bias_bank_loader_if #(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned DEPTH      = 15,
   parameter int unsigned NUM_LAYERS = 2
);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

   logic                  load_start;
   logic [LW-1:0]         load_layer;
   logic                  load_valid;
   logic [WIDTH-1:0]      load_data;
   logic                  load_ready;
   logic                  load_done;
   logic [NUM_LAYERS-1:0] bank_loaded;
   logic                  rd_en;
   logic [LW-1:0]         rd_layer;
   logic [AW-1:0]         rd_addr;
   logic                  rd_valid;
   logic [WIDTH-1:0]      rd_data;
   logic                  rd_err;

   modport master (
      output load_start, load_layer, load_valid, load_data,
      output rd_en, rd_layer, rd_addr,
      input  load_ready, load_done, bank_loaded,
      input  rd_valid, rd_data, rd_err
   );

   modport slave (
      input  load_start, load_layer, load_valid, load_data,
      input  rd_en, rd_layer, rd_addr,
      output load_ready, load_done, bank_loaded,
      output rd_valid, rd_data, rd_err
   );
endinterface

// File: rtl/bias_bank_loader.sv
// Multi-bank signed bias storage: streaming valid/ready bank loader with an
// auto-incrementing write pointer and a single registered read port.
module bias_bank_loader #(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned DEPTH      = 15,
   parameter int unsigned NUM_LAYERS = 2
) (
   input logic               clk,
   input logic               reset,
   bias_bank_loader_if.slave bus
);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [WIDTH-1:0]      mem [NUM_LAYERS][DEPTH];

   logic [1:0]            state_q,  state_d;
   logic [AW-1:0]         wptr_q,   wptr_d;
   logic [LW-1:0]         layer_q,  layer_d;
   logic                  ready_q,  ready_d;
   logic                  done_q,   done_d;
   logic [NUM_LAYERS-1:0] loaded_q, loaded_d;
   logic                  wr_en;

   logic                  rd_valid_q;
   logic [WIDTH-1:0]      rd_data_q;
   logic                  rd_err_q;
   logic                  layer_ok;
   logic                  addr_ok;
   logic                  rd_ok;

   // Loader state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         wptr_q   <= '0;
         layer_q  <= '0;
         ready_q  <= 1'b0;
         done_q   <= 1'b0;
         loaded_q <= '0;
      end else begin
         state_q  <= state_d;
         wptr_q   <= wptr_d;
         layer_q  <= layer_d;
         ready_q  <= ready_d;
         done_q   <= done_d;
         loaded_q <= loaded_d;
      end
   end

   // Loader next-state; ready/done are registered copies of the next state
   always_comb begin
      state_d  = state_q;
      wptr_d   = wptr_q;
      layer_d  = layer_q;
      loaded_d = loaded_q;
      wr_en    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.load_start && (32'(bus.load_layer) < NUM_LAYERS)) begin
               layer_d                 = bus.load_layer;
               wptr_d                  = '0;
               loaded_d[bus.load_layer] = 1'b0;
               state_d                 = S_LOAD;
            end
         end
         S_LOAD: begin
            if (bus.load_valid && ready_q) begin
               wr_en  = 1'b1;
               wptr_d = wptr_q + AW'(1);
               if (32'(wptr_q) == DEPTH - 1) begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            loaded_d[layer_q] = 1'b1;
            state_d           = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      ready_d = (state_d == S_LOAD);
      done_d  = (state_d == S_DONE);
   end

   // Bias storage; reset clears every bank
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int l = 0; l < int'(NUM_LAYERS); l++) begin
            for (int d = 0; d < int'(DEPTH); d++) begin
               mem[l][d] <= '0;
            end
         end
      end else if (wr_en) begin
         mem[layer_q][wptr_q] <= bus.load_data;
      end
   end

   // A read is served only from a fully loaded bank and an in-range entry
   always_comb begin
      layer_ok = (32'(bus.rd_layer) < NUM_LAYERS);
      addr_ok  = (32'(bus.rd_addr) < DEPTH);
      rd_ok    = 1'b0;
      if (layer_ok && addr_ok) begin
         rd_ok = loaded_q[bus.rd_layer];
      end
   end

   // Registered read port; data/err hold when no read is issued
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         rd_err_q   <= 1'b0;
      end else begin
         rd_valid_q <= bus.rd_en;
         if (bus.rd_en) begin
            rd_err_q  <= ~rd_ok;
            rd_data_q <= rd_ok ? mem[bus.rd_layer][bus.rd_addr] : '0;
         end
      end
   end

   assign bus.load_ready  = ready_q;
   assign bus.load_done   = done_q;
   assign bus.bank_loaded = loaded_q;
   assign bus.rd_valid    = rd_valid_q;
   assign bus.rd_data     = rd_data_q;
   assign bus.rd_err      = rd_err_q;
endmodule
